number_to_ascii6digit: RTL and testbench

Sequential binary-to-ASCII converter: takes a 32-bit unsigned number and produces six ASCII decimal digit characters, using serial double-dabble (shift-add-3) over 20 cycles. It is the inverse of the six-digit ASCII-to-number path, and feeds display/UART text output in the project's main datapath. The byte layout is identical to the ASCII input side, so the packed 48-bit result is directly compatible with it.

---
 rtl/number_to_ascii6digit_pkg.sv | 32 +++
 rtl/number_to_ascii6digit_dabble_nibble.sv | 10 +
 rtl/number_to_ascii6digit.sv | 112 +++++++++++
 tb/tb_number_to_ascii6digit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/number_to_ascii6digit_pkg.sv
// Shared constants for the six-digit ASCII number paths. The ASCII-to-number
// side uses the same values, so both directions agree on the byte layout.
package number_to_ascii6digit_pkg;

    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [31:0] MAX_VALUE   = 32'd999999;
    localparam int          NUM_DIGITS  = 6;
    localparam int          SHIFT_BITS  = 20;   // 999999 < 2^20
    localparam int          BCD_W       = 4 * NUM_DIGITS;
    localparam int          ASCII_W     = 8 * NUM_DIGITS;

    // Packed BCD to ASCII; with blank set, leading zero digits become spaces.
    // The ones digit is always printed so that zero shows as "     0".
    function automatic logic [ASCII_W-1:0] bcd_to_ascii(input logic [BCD_W-1:0] bcd,
                                                        input logic            blank);
        logic [ASCII_W-1:0] res;
        logic               lead;
        res  = '0;
        lead = blank;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (lead && (i != 0) && (bcd[4*i +: 4] == 4'h0)) begin
                res[8*i +: 8] = ASCII_SPACE;
            end else begin
                res[8*i +: 8] = ASCII_ZERO | {4'h0, bcd[4*i +: 4]};
                lead          = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/number_to_ascii6digit_dabble_nibble.sv
// One BCD digit correction step of double-dabble: add 3 when the digit is
// 5 or more so that the following left shift carries into the next digit.
module dabble_nibble (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/number_to_ascii6digit.sv
// Serial binary-to-ASCII converter: 32-bit unsigned in, six ASCII decimal
// digits out. Values above 999999 saturate and raise overflow. One shift per
// clock, result valid (done pulse) 20 clocks after the accepting edge.
module number_to_ascii6digit
    import number_to_ascii6digit_pkg::*;
#(
    parameter int unsigned LEADING_ZERO_BLANK = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         number,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [ASCII_W-1:0]  ascii
);

    localparam logic               BLANK     = (LEADING_ZERO_BLANK != 0);
    localparam logic [0:0]         IDLE      = 1'b0;
    localparam logic [0:0]         SHIFT     = 1'b1;
    localparam logic [4:0]         LAST_CNT  = 5'(SHIFT_BITS - 1);
    localparam logic [ASCII_W-1:0] ASCII_RST = BLANK ? 48'h202020202030 : 48'h303030303030;

    logic [0:0]            state_q, state_d;
    logic [SHIFT_BITS-1:0] bin_q,   bin_d;
    logic [BCD_W-1:0]      bcd_q,   bcd_d;
    logic [4:0]            cnt_q,   cnt_d;
    logic                  pend_q,  pend_d;
    logic                  done_q,  done_d;
    logic                  ovf_q,   ovf_d;
    logic [ASCII_W-1:0]    ascii_q, ascii_d;
    logic [BCD_W-1:0]      bcd_adj;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        dabble_nibble u_dab (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    // Next-state: accept in IDLE, shift one bit per clock, format on the last shift.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        ascii_d = ascii_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (number > MAX_VALUE) begin
                        bin_d  = MAX_VALUE[SHIFT_BITS-1:0];
                        pend_d = 1'b1;
                    end else begin
                        bin_d  = number[SHIFT_BITS-1:0];
                        pend_d = 1'b0;
                    end
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[SHIFT_BITS-1]};
                bin_d = {bin_q[SHIFT_BITS-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    // bcd_d already holds the fully shifted result here.
                    ascii_d = bcd_to_ascii(bcd_d, BLANK);
                    ovf_d   = pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any conversion in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ascii_q <= ASCII_RST;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            ascii_q <= ascii_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign ascii    = ascii_q;

endmodule

// File: tb/tb_number_to_ascii6digit.sv
// Bench for number_to_ascii6digit: a plain and a blanking instance share the
// same stimulus and are compared against a divide/modulo reference model.
module tb_number_to_ascii6digit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] number = '0;
    logic        busy0, done0, ovf0;
    logic        busy1, done1, ovf1;
    logic [47:0] asc0, asc1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    number_to_ascii6digit #(.LEADING_ZERO_BLANK(0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .number(number),
        .busy(busy0), .done(done0), .overflow(ovf0), .ascii(asc0)
    );

    number_to_ascii6digit #(.LEADING_ZERO_BLANK(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .number(number),
        .busy(busy1), .done(done1), .overflow(ovf1), .ascii(asc1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: saturate, split into decimal digits, print with optional blanking.
    function automatic logic [47:0] ref_ascii(input logic [31:0] n, input bit blank);
        int          v;
        int          d[6];
        bit          lead;
        logic [47:0] r;
        v = (n > 32'd999999) ? 999999 : int'(n);
        for (int i = 0; i < 6; i++) begin
            d[i] = v % 10;
            v    = v / 10;
        end
        lead = blank;
        r    = '0;
        for (int i = 5; i >= 0; i--) begin
            if (lead && i > 0 && d[i] == 0) r[8*i +: 8] = 8'h20;
            else begin
                lead        = 1'b0;
                r[8*i +: 8] = 8'h30 + 8'(d[i]);
            end
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] n);
        return n > 32'd999999;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, busy0}, 64'd0);
        chk({tag, "_done"}, {63'd0, done0}, 64'd0);
        chk({tag, "_ovf"},  {63'd0, ovf0},  64'd0);
        chk({tag, "_asc0"}, {16'd0, asc0},  {16'd0, 48'h303030303030});
        chk({tag, "_asc1"}, {16'd0, asc1},  {16'd0, 48'h202020202030});
    endtask

    // One conversion: check latency, busy window, result of both instances.
    task automatic run_conv(input logic [31:0] n);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clock);
        start  = 1'b1;
        number = n;
        @(posedge clock);
        #1;
        start    = 1'b0;
        number   = $urandom;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        if (busy0) busy_cnt++;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clock);
            #1;
            if (done0) begin
                seen = 1'b1;
                lat  = k;
            end else if (busy0) busy_cnt++;
        end
        chk("done_seen",    {63'd0, seen},  64'd1);
        chk("latency",      64'(lat),       64'd20);
        chk("busy_cycles",  64'(busy_cnt),  64'd20);
        chk("busy_at_done", {63'd0, busy0}, 64'd0);
        chk("done_blank",   {63'd0, done1}, 64'd1);
        chk("ascii",        {16'd0, asc0},  {16'd0, ref_ascii(n, 1'b0)});
        chk("ascii_blank",  {16'd0, asc1},  {16'd0, ref_ascii(n, 1'b1)});
        chk("overflow",     {63'd0, ovf0},  {63'd0, ref_ovf(n)});
        chk("ovf_blank",    {63'd0, ovf1},  {63'd0, ref_ovf(n)});
        @(posedge clock);
        #1;
        chk("done_pulse",   {63'd0, done0}, 64'd0);
        chk("ascii_hold",   {16'd0, asc0},  {16'd0, ref_ascii(n, 1'b0)});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ndone;
        int times[$];
        logic [47:0] cap;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        // Directed values including saturation boundaries
        run_conv(32'd0);
        run_conv(32'd123456);
        run_conv(32'd999999);
        run_conv(32'd1000000);

        // Mid-conversion reset: aborts with no done pulse
        @(negedge clock);
        start  = 1'b1;
        number = 32'd500000;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        ndone = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done0 || done1) ndone++;
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (done0 || done1) ndone++;
        end
        chk("midreset_no_done", 64'(ndone), 64'd0);
        run_conv(32'd7);

        run_conv(32'hFFFFFFFF);
        run_conv(32'd42);
        run_conv(32'd100000);
        run_conv(32'd10);

        // Busy rejection: second request during conversion is dropped
        @(negedge clock);
        start  = 1'b1;
        number = 32'd42;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        start  = 1'b1;
        number = 32'd777;
        @(posedge clock);
        #1;
        start = 1'b0;
        ndone = 0;
        cap   = '0;
        for (int k = 6; k <= 50; k++) begin
            @(posedge clock);
            #1;
            if (done0) begin
                ndone++;
                cap = asc0;
            end
        end
        chk("reject_ndone", 64'(ndone), 64'd1);
        chk("reject_ascii", {16'd0, cap}, {16'd0, 48'h303030303432});

        // Start held high: one completion every 21 clocks
        @(negedge clock);
        start  = 1'b1;
        number = 32'd314159;
        for (int k = 0; k <= 70; k++) begin
            @(posedge clock);
            #1;
            if (done0) begin
                times.push_back(k);
                chk("held_ascii", {16'd0, asc0}, {16'd0, 48'h333134313539});
            end
        end
        @(negedge clock);
        start = 1'b0;
        chk("held_count", 64'(times.size()), 64'd3);
        if (times.size() == 3) begin
            chk("held_first",  64'(times[0]), 64'd20);
            chk("held_period", 64'(times[1] - times[0]), 64'd21);
            chk("held_period", 64'(times[2] - times[1]), 64'd21);
        end
        repeat (25) @(posedge clock);

        // Randomized values
        for (int i = 0; i < 20; i++) run_conv(32'($urandom_range(0, 999999)));
        for (int i = 0; i < 5; i++) run_conv($urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
